// File: rtl/pipeline_event_monitor_pkg.sv
// Shared types and helpers for the pipeline event monitor.
package pipeline_event_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2,
    DONE   = 2'd3
  } mon_state_e;

  // Readout select width; a single channel still needs a 1-bit select.
  function automatic int SEL_WIDTH(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipeline_event_monitor_event_counter.sv
// One saturating event counter with a sticky saturation flag.
module event_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 sat_o
);

  localparam logic [CNT_WIDTH-1:0] ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] MAX_M1 = MAX - ONE;

  // The flag rises on the increment that lands on full scale.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
      sat_o <= 1'b0;
    end else if (clr_i) begin
      cnt_o <= '0;
      sat_o <= 1'b0;
    end else if (inc_i) begin
      if (cnt_o != MAX) cnt_o <= cnt_o + ONE;
      if (cnt_o >= MAX_M1) sat_o <= 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_event_monitor.sv
// Windowed per-channel hazard event counters with freeze, cycle limit and a
// registered single-channel readout.
module pipeline_event_monitor
  import pipeline_event_monitor_pkg::*;
#(
  parameter int NUM_EVENTS  = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int CYCLE_LIMIT = 0
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic [NUM_EVENTS-1:0]               event_i,
  input  logic                                freeze_i,
  input  logic                                clear_i,
  input  logic [SEL_WIDTH(NUM_EVENTS)-1:0]    sel_i,
  output logic [CNT_WIDTH-1:0]                count_o,
  output logic [CNT_WIDTH-1:0]                cycle_o,
  output logic [NUM_EVENTS-1:0]               sat_o,
  output logic                                done_o,
  output logic                                busy_o
);

  localparam int                   SW       = SEL_WIDTH(NUM_EVENTS);
  localparam bit                   LIMITED  = (CYCLE_LIMIT != 0);
  localparam logic [CNT_WIDTH-1:0] LIMIT_M1 = CNT_WIDTH'(CYCLE_LIMIT - 1);

  mon_state_e           state;
  logic                 count_en;
  logic                 limit_hit;
  logic                 cycle_sat;
  logic [CNT_WIDTH-1:0] ev_cnt [NUM_EVENTS];
  logic [CNT_WIDTH-1:0] rd_val;

  // Resuming from FROZEN counts in the same cycle freeze_i drops.
  assign count_en  = !clear_i && !freeze_i && ((state == RUN) || (state == FROZEN));
  assign limit_hit = LIMITED && count_en && !cycle_sat && (cycle_o == LIMIT_M1);

  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_evt
    event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_evt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .inc_i (count_en & event_i[g]),
      .cnt_o (ev_cnt[g]),
      .sat_o (sat_o[g])
    );
  end

  event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clear_i),
    .inc_i (count_en),
    .cnt_o (cycle_o),
    .sat_o (cycle_sat)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      done_o <= 1'b0;
      busy_o <= 1'b0;
    end else if (clear_i) begin
      state  <= IDLE;
      done_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state  <= RUN;
            busy_o <= 1'b1;
          end
        end
        RUN, FROZEN: begin
          if (freeze_i) begin
            state <= FROZEN;
          end else if (limit_hit) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_EVENTS; k++) begin
      if (sel_i == SW'(k)) rd_val = ev_cnt[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) count_o <= '0;
    else        count_o <= rd_val;
  end

endmodule

// File: tb/tb_pipeline_event_monitor.sv
// Bench for pipeline_event_monitor: an unbounded 4-bit instance and a
// CYCLE_LIMIT=8 instance share stimulus and are scored against a model.
module tb_pipeline_event_monitor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] ev;
  logic       frz;
  logic       clr;
  logic [1:0] sel;

  logic [3:0] a_cnt, a_cyc;
  logic [2:0] a_sat;
  logic       a_done, a_busy;
  logic [7:0] b_cnt, b_cyc;
  logic [2:0] b_sat;
  logic       b_done, b_busy;

  pipeline_event_monitor #(.NUM_EVENTS(3), .CNT_WIDTH(4), .CYCLE_LIMIT(0)) u_a (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .event_i(ev), .freeze_i(frz),
    .clear_i(clr), .sel_i(sel), .count_o(a_cnt), .cycle_o(a_cyc), .sat_o(a_sat),
    .done_o(a_done), .busy_o(a_busy)
  );

  pipeline_event_monitor #(.NUM_EVENTS(3), .CNT_WIDTH(8), .CYCLE_LIMIT(8)) u_b (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .event_i(ev), .freeze_i(frz),
    .clear_i(clr), .sel_i(sel), .count_o(b_cnt), .cycle_o(b_cyc), .sat_o(b_sat),
    .done_o(b_done), .busy_o(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic [7:0] cnt;
    logic [7:0] cyc;
    logic [2:0] sat;
    logic       done;
    logic       busy;
  } exp_t;
  exp_t sbq[$];

  // Model state per instance: 0 idle, 1 run, 2 frozen, 3 done.
  int       m_st   [2];
  int       m_cnt  [2][3];
  int       m_cyc  [2];
  bit [2:0] m_sat  [2];
  int       m_cnto [2];
  int       MAXV   [2] = '{15, 255};
  int       LIM    [2] = '{0, 8};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_cyc[i] = 0; m_sat[i] = '0; m_cnto[i] = 0;
      for (int k = 0; k < 3; k++) m_cnt[i][k] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic st, input logic [2:0] e,
                            input logic fr, input logic cl, input logic [1:0] s);
    if (s < 2'd3) m_cnto[i] = m_cnt[i][s];
    else          m_cnto[i] = 0;
    if (cl) begin
      m_st[i] = 0; m_cyc[i] = 0; m_sat[i] = '0;
      for (int k = 0; k < 3; k++) m_cnt[i][k] = 0;
    end else if (m_st[i] == 0) begin
      if (st) m_st[i] = 1;
    end else if (m_st[i] == 1 || m_st[i] == 2) begin
      if (fr) m_st[i] = 2;
      else begin
        if (m_cyc[i] < MAXV[i]) m_cyc[i]++;
        for (int k = 0; k < 3; k++) begin
          if (e[k]) begin
            if (m_cnt[i][k] < MAXV[i]) m_cnt[i][k]++;
            if (m_cnt[i][k] == MAXV[i]) m_sat[i][k] = 1'b1;
          end
        end
        m_st[i] = (LIM[i] != 0 && m_cyc[i] == LIM[i]) ? 3 : 1;
      end
    end
  endtask

  // One clock: drive, predict into the scoreboard, then score both instances.
  task automatic cyc(input logic st, input logic [2:0] e, input logic fr,
                     input logic cl, input logic [1:0] s);
    exp_t x;
    start = st; ev = e; frz = fr; clr = cl; sel = s;
    for (int i = 0; i < 2; i++) begin
      model_step(i, st, e, fr, cl, s);
      x.cnt  = 8'(m_cnto[i]);
      x.cyc  = 8'(m_cyc[i]);
      x.sat  = m_sat[i];
      x.done = (m_st[i] == 3);
      x.busy = (m_st[i] == 1 || m_st[i] == 2);
      sbq.push_back(x);
    end
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    chk("A.count_o", 32'(a_cnt), 32'(x.cnt));
    chk("A.cycle_o", 32'(a_cyc), 32'(x.cyc));
    chk("A.sat_o",   32'(a_sat), 32'(x.sat));
    chk("A.done_o",  32'(a_done), 32'(x.done));
    chk("A.busy_o",  32'(a_busy), 32'(x.busy));
    x = sbq.pop_front();
    chk("B.count_o", 32'(b_cnt), 32'(x.cnt));
    chk("B.cycle_o", 32'(b_cyc), 32'(x.cyc));
    chk("B.sat_o",   32'(b_sat), 32'(x.sat));
    chk("B.done_o",  32'(b_done), 32'(x.done));
    chk("B.busy_o",  32'(b_busy), 32'(x.busy));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".A.count_o"}, 32'(a_cnt), 0);
    chk({tag, ".A.cycle_o"}, 32'(a_cyc), 0);
    chk({tag, ".A.sat_o"},   32'(a_sat), 0);
    chk({tag, ".A.done_o"},  32'(a_done), 0);
    chk({tag, ".A.busy_o"},  32'(a_busy), 0);
    chk({tag, ".B.count_o"}, 32'(b_cnt), 0);
    chk({tag, ".B.cycle_o"}, 32'(b_cyc), 0);
    chk({tag, ".B.done_o"},  32'(b_done), 0);
    chk({tag, ".B.busy_o"},  32'(b_busy), 0);
  endtask

  // Phase table: inputs held for n cycles, then hand-derived end values.
  typedef struct {
    logic       st;
    logic [2:0] e;
    logic       fr;
    logic       cl;
    logic [1:0] s;
    int         n;
    int         exp_cyc_b;
    logic       exp_done_b;
    int         exp_cnt_a;   // -1: not checked at this phase end
    logic [2:0] exp_sat_a;
  } phase_t;

  phase_t ph[17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ph[0]  = '{1'b1, 3'b001, 1'b0, 1'b0, 2'd0,  1, 0, 1'b0, -1, 3'b000};
    ph[1]  = '{1'b0, 3'b001, 1'b0, 1'b0, 2'd0,  3, 3, 1'b0, -1, 3'b000};
    ph[2]  = '{1'b0, 3'b000, 1'b0, 1'b0, 2'd0,  1, 4, 1'b0,  3, 3'b000};
    ph[3]  = '{1'b0, 3'b111, 1'b1, 1'b0, 2'd0,  5, 4, 1'b0,  3, 3'b000};
    ph[4]  = '{1'b0, 3'b010, 1'b0, 1'b0, 2'd0,  2, 6, 1'b0,  3, 3'b000};
    ph[5]  = '{1'b0, 3'b010, 1'b0, 1'b0, 2'd0,  1, 7, 1'b0, -1, 3'b000};
    ph[6]  = '{1'b0, 3'b010, 1'b1, 1'b0, 2'd0,  1, 7, 1'b0, -1, 3'b000};
    ph[7]  = '{1'b0, 3'b010, 1'b0, 1'b0, 2'd0,  1, 8, 1'b1, -1, 3'b000};
    ph[8]  = '{1'b0, 3'b111, 1'b0, 1'b0, 2'd0,  3, 8, 1'b1, -1, 3'b000};
    ph[9]  = '{1'b0, 3'b000, 1'b0, 1'b0, 2'd1,  1, 8, 1'b1,  7, 3'b000};
    ph[10] = '{1'b0, 3'b000, 1'b0, 1'b0, 2'd3,  1, 8, 1'b1,  0, 3'b000};
    ph[11] = '{1'b0, 3'b000, 1'b0, 1'b0, 2'd2,  1, 8, 1'b1,  3, 3'b000};
    ph[12] = '{1'b0, 3'b001, 1'b0, 1'b1, 2'd0,  1, 0, 1'b0, -1, 3'b000};
    ph[13] = '{1'b1, 3'b000, 1'b0, 1'b0, 2'd2,  1, 0, 1'b0,  0, 3'b000};
    ph[14] = '{1'b0, 3'b100, 1'b0, 1'b0, 2'd2, 20, 8, 1'b1, 15, 3'b100};
    ph[15] = '{1'b0, 3'b000, 1'b0, 1'b0, 2'd2,  2, 8, 1'b1, 15, 3'b100};
    ph[16] = '{1'b0, 3'b000, 1'b0, 1'b1, 2'd2,  1, 0, 1'b0, -1, 3'b000};

    rst_n = 1'b0; start = 1'b0; ev = '0; frz = 1'b0; clr = 1'b0; sel = '0;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int p = 0; p < 17; p++) begin
      for (int c = 0; c < ph[p].n; c++) cyc(ph[p].st, ph[p].e, ph[p].fr, ph[p].cl, ph[p].s);
      chk($sformatf("ph%0d.B.cycle_o", p), 32'(b_cyc), ph[p].exp_cyc_b);
      chk($sformatf("ph%0d.B.done_o", p), 32'(b_done), 32'(ph[p].exp_done_b));
      chk($sformatf("ph%0d.A.sat_o", p), 32'(a_sat), 32'(ph[p].exp_sat_a));
      if (ph[p].exp_cnt_a >= 0)
        chk($sformatf("ph%0d.A.count_o", p), 32'(a_cnt), ph[p].exp_cnt_a);
    end

    // Asynchronous reset between edges while running.
    cyc(1'b1, 3'b000, 1'b0, 1'b0, 2'd0);
    for (int c = 0; c < 3; c++) cyc(1'b0, 3'b001, 1'b0, 1'b0, 2'd0);
    #3;
    rst_n = 1'b0;
    start = 1'b0; ev = '0; frz = 1'b0; clr = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 3'b000, 1'b0, 1'b0, 2'd0);
    for (int c = 0; c < 2; c++) cyc(1'b0, 3'b001, 1'b0, 1'b0, 2'd0);
    cyc(1'b0, 3'b000, 1'b0, 1'b0, 2'd0);
    chk("restart.A.count_o", 32'(a_cnt), 2);
    chk("restart.B.cycle_o", 32'(b_cyc), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
